pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Registered program counter with an integrated parametrised hardware return stack.
//  It decodes the 12-bit instruction fetched at the current PC, plus the ALU Z flag and PCL writes.
//  From these it selects the next PC: increment, skip, GOTO, CALL, RETLW or computed PCL.
//  It sits between program ROM (address = pc) and the register file/ALU of the mini-CPU core.
// PARAMETERS
//  PC_W        9        program counter width in bits (>= 9)
//  STACK_DEPTH 2        return stack entries (>= 1)
//  RST_VEC     all-1s   PC value loaded on reset (PC_W bits, default 9'h1FF)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        reset, synchronous, active-high
//  en         in   1        advance enable; 0 = hold pc, stack and flags
//  instr      in   12       instruction at current pc (combinational ROM data)
//  z          in   1        zero/bit-test result for the current instruction
//  pcl_wr     in   1        current instruction writes PCL
//  f_in_data  in   8        data written to PCL
//  pc         out  PC_W     current program counter (registered)
//  pcl1       out  8        low byte of pc+1 (PCL read value)
//  stk_lvl    out  clog2(STACK_DEPTH+1)  occupied stack entries
//  stk_ovf    out  1        sticky: push while stack full
//  stk_unf    out  1        sticky: pop while stack empty
// BEHAVIOUR
//  Reset (clk edge with rst=1): pc=RST_VEC; all stack entries=0; stk_lvl=0; stk_ovf=stk_unf=0.
//  Latency: next-PC is combinational from instr/z/pcl_wr; it is loaded into pc on the next edge with en=1.
//  en=0: no state changes, including stack and flags.
//  Decode priority, first match wins (K = instr bits, zero-extended to PC_W):
//   101k_kkkk_kkkk   GOTO    pc <= instr[8:0]
//   1001_kkkk_kkkk   CALL    push(pc+1); pc <= {0, instr[7:0]}
//   1000_kkkk_kkkk   RETLW   pc <= top; pop
//   0111_xxxx_xxxx & z=0   BTFSS skip: pc <= pc+2
//   0110_xxxx_xxxx & z=1   BTFSC skip: pc <= pc+2
//   0011_11xx_xxxx & z=1   INCFSZ skip: pc <= pc+2
//   0010_11xx_xxxx & z=1   DECFSZ skip: pc <= pc+2
//   otherwise: pcl_wr=1 -> pc <= {0, f_in_data}; else pc <= pc+1
//  Arithmetic: pc+1 and pc+2 wrap modulo 2^PC_W (0x1FF+1 = 0x000 at PC_W=9).
//  Stack: shift-register organisation; entry 0 = top.
//   push: entry[i] <= entry[i-1]; entry[0] <= pc+1; the oldest entry is discarded.
//   pop: entry[i-1] <= entry[i]; the bottom entry is kept (duplicated).
//  stk_lvl: push increments it, saturating at STACK_DEPTH; pop decrements it, saturating at 0.
//  CALL and RETLW never occur in the same cycle; pcl_wr is ignored on GOTO/CALL/RETLW/skip.
//  A reset asserted mid-sequence (e.g. during a nested call) discards all stack contents.
// CONFIGURATION
//  Macro SEQ_STACK_GUARD_EN.
//  Defined:
//   - push at stk_lvl==STACK_DEPTH sets stk_ovf; the push still shifts and drops the oldest entry.
//   - pop at stk_lvl==0 sets stk_unf; pc still loads entry 0.
//   - both flags hold until rst.
//  Not defined: stk_ovf=stk_unf=0 constantly; stack behaviour is unchanged; no flag logic synthesised.
// TESTING
//  T1 rst=1 one edge, then en=1 with instr=NOP (000) -> pc 0x1FF then 0x000 (wrap), pcl1=0x01.
//  T2 pc=0x010, instr=0x905 (CALL 0x05) -> pc=0x005, entry0=0x011, stk_lvl=1;
//     then instr=0x8AA (RETLW) -> pc=0x011, stk_lvl=0.
//  T3 at pc=0x020:
//     instr=0x7E3 with z=1 -> pc=0x021; with z=0 -> pc=0x022.
//     instr=0x2C0 (DECFSZ) with z=1 -> pc+2.
//  T4 instr=0xB3C (GOTO 0x13C) -> pc=0x13C;
//     instr=0x020 with pcl_wr=1, f_in_data=0x7F -> pc=0x07F.
//  T5 STACK_DEPTH=2, three CALLs from pc=0x00,0x10,0x20 -> entries {0x21,0x11}, stk_lvl=2;
//     SEQ_STACK_GUARD_EN on -> stk_ovf=1 (off -> 0).
//     Then 3 RETLWs -> pc 0x21, 0x11, 0x11; stk_unf=1 on the third (guard on only).
//  T6 en=0 for 5 cycles with instr=CALL -> pc, stk_lvl and stack unchanged;
//     rst during a nested call -> pc=0x1FF, stk_lvl=0, flags cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Registered program counter with a shift-register return stack.
//            Optional stack overflow/underflow flags: define SEQ_STACK_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               PC_W        = 9,
    parameter int               STACK_DEPTH = 2,
    parameter logic [PC_W-1:0]  RST_VEC     = {PC_W{1'b1}}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [11:0]                        instr,
    input  logic                               z,
    input  logic                               pcl_wr,
    input  logic [7:0]                         f_in_data,
    output logic [PC_W-1:0]                    pc,
    output logic [7:0]                         pcl1,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_lvl,
    output logic                               stk_ovf,
    output logic                               stk_unf
);

    localparam int              LVL_W     = $clog2(STACK_DEPTH+1);
    localparam logic [LVL_W-1:0] c_LVL_MAX = LVL_W'(STACK_DEPTH);

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_stack [STACK_DEPTH];
    logic [LVL_W-1:0] r_lvl;

    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_pc_skip;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_goto;
    logic             w_call;
    logic             w_ret;
    logic             w_skip;
    logic             w_full;
    logic             w_empty;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_skip = r_pc + PC_W'(2);

    // Decode in priority order; skips only qualify when no branch matched.
    assign w_goto = (instr[11:9] == 3'b101);
    assign w_call = (instr[11:8] == 4'b1001);
    assign w_ret  = (instr[11:8] == 4'b1000);
    assign w_skip = ((instr[11:8] == 4'b0111) && !z) ||
                    ((instr[11:8] == 4'b0110) &&  z) ||
                    ((instr[11:6] == 6'b001111) && z) ||
                    ((instr[11:6] == 6'b001011) && z);

    assign w_full  = (r_lvl == c_LVL_MAX);
    assign w_empty = (r_lvl == '0);

    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_goto) begin
            w_pc_next = PC_W'(instr[8:0]);
        end else if (w_call) begin
            w_pc_next = PC_W'(instr[7:0]);
        end else if (w_ret) begin
            w_pc_next = r_stack[0];
        end else if (w_skip) begin
            w_pc_next = w_pc_skip;
        end else if (pcl_wr) begin
            w_pc_next = PC_W'(f_in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RST_VEC;
            r_lvl <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (en) begin
            r_pc <= w_pc_next;
            if (w_call && !w_goto) begin
                for (int i = 1; i < STACK_DEPTH; i++) begin
                    r_stack[i] <= r_stack[i-1];
                end
                r_stack[0] <= w_pc_inc;
                if (!w_full) begin
                    r_lvl <= r_lvl + LVL_W'(1);
                end
            end else if (w_ret && !w_goto) begin
                // Bottom entry is left in place so it is duplicated upward.
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    r_stack[i] <= r_stack[i+1];
                end
                if (!w_empty) begin
                    r_lvl <= r_lvl - LVL_W'(1);
                end
            end
        end
    end

`ifdef SEQ_STACK_GUARD_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (en) begin
            if (w_call && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_ret && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;
`else
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

    assign pc      = r_pc;
    assign pcl1    = w_pc_inc[7:0];
    assign stk_lvl = r_lvl;

endmodule
`default_nettype wire
